rat_int_seq: RTL

Interrupt sequencer for the RAT CPU; the control-side partner of the flag register. It synchronizes and edge-detects the external interrupt and holds the interrupt-enable (I) flag. It saves C/Z into shadow registers on interrupt entry and produces the flag-register control strobes that restore them on RETIE/RETID. It sits between the board interrupt pin, the control unit (instruction strobes, PC vectoring) and the flag register.

---
 rtl/rat_int_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rat_int_seq.sv
// rat_int_seq: RAT CPU interrupt sequencer.
// Syncs INTR, holds I flag, shadows C/Z and drives flag restore strobes.
module rat_int_seq (
  input  logic CLK,
  input  logic RST_N,
  input  logic INTR,
  input  logic INSTR_DONE,
  input  logic SEI,
  input  logic CLI,
  input  logic RETIE,
  input  logic RETID,
  input  logic C_FLAG,
  input  logic Z_FLAG,
  output logic I_FLAG,
  output logic IN_ISR,
  output logic INT_ACK,
  output logic FLG_SHAD_LD,
  output logic FLG_LD_SEL,
  output logic FLG_C_LD,
  output logic FLG_Z_LD,
  output logic SHAD_C,
  output logic SHAD_Z
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    VECTOR,
    ISR,
    RESTORE
  } state_t;

  state_t state_q, state_d;
  logic s1_q, s2_q, s3_q;
  logic pend_q, pend_d;
  logic i_flag_q, i_flag_d;
  logic shad_c_q, shad_c_d;
  logic shad_z_q, shad_z_d;
  logic ret_ie_q, ret_ie_d;
  logic rise, go, in_isr;

  assign rise   = s2_q & ~s3_q;
  assign go     = (state_q == IDLE) & pend_q & i_flag_q & INSTR_DONE;
  assign in_isr = (state_q == VECTOR) | (state_q == ISR) |
                  (state_q == RESTORE);

  // A new edge in the entry cycle keeps the request pending
  assign pend_d = rise | (pend_q & ~go);

  always_comb begin
    state_d  = state_q;
    i_flag_d = i_flag_q;
    shad_c_d = shad_c_q;
    shad_z_d = shad_z_q;
    ret_ie_d = ret_ie_q;
    if (!in_isr) begin
      if (CLI)      i_flag_d = 1'b0;
      else if (SEI) i_flag_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d  = SAVE;
          i_flag_d = 1'b0;
        end
      end
      SAVE: begin
        state_d  = VECTOR;
        shad_c_d = C_FLAG;
        shad_z_d = Z_FLAG;
      end
      VECTOR: state_d = ISR;
      ISR: begin
        if (RETID) begin
          state_d  = RESTORE;
          ret_ie_d = 1'b0;
        end else if (RETIE) begin
          state_d  = RESTORE;
          ret_ie_d = 1'b1;
        end
      end
      RESTORE: begin
        state_d  = IDLE;
        i_flag_d = ret_ie_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      pend_q   <= 1'b0;
      i_flag_q <= 1'b0;
      shad_c_q <= 1'b0;
      shad_z_q <= 1'b0;
      ret_ie_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= INTR;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      pend_q   <= pend_d;
      i_flag_q <= i_flag_d;
      shad_c_q <= shad_c_d;
      shad_z_q <= shad_z_d;
      ret_ie_q <= ret_ie_d;
    end
  end

  assign I_FLAG      = i_flag_q;
  assign IN_ISR      = in_isr;
  assign INT_ACK     = (state_q == VECTOR);
  assign FLG_SHAD_LD = (state_q == SAVE);
  assign FLG_LD_SEL  = (state_q == RESTORE);
  assign FLG_C_LD    = (state_q == RESTORE);
  assign FLG_Z_LD    = (state_q == RESTORE);
  assign SHAD_C      = shad_c_q;
  assign SHAD_Z      = shad_z_q;

endmodule
